// File: rtl/startup_pkg.sv
// Shared state encoding, defaults and per-state output decode for the startup sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package startup_pkg;

    localparam int STATE_W = 3;

    localparam int LOCK_STABLE_CYCLES_DEF = 16;
    localparam int ROC_CYCLES_DEF         = 100;
    localparam int TOC_CYCLES_DEF         = 0;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_LOCK = 3'd0,
        S_GSR       = 3'd1,
        S_GTS       = 3'd2,
        S_GWE       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Output levels that hold while in a given state, packed as {gsr, gts, gwe, done}.
    // prld shares the gsr bit.
    function automatic logic [3:0] state_outputs(input state_t s);
        logic [3:0] o;
        o = 4'b1100;
        case (s)
            S_WAIT_LOCK: o = 4'b1100;
            S_GSR:       o = 4'b1100;
            S_GTS:       o = 4'b0100;
            S_GWE:       o = 4'b0010;
            S_DONE:      o = 4'b0011;
            default:     o = 4'b1100;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/startup_cnt.sv
// Clear/enable up-counter with a terminal-match flag against a runtime limit.
// Latency: count updates one cycle after clr/en; match is combinational on count.
// Backpressure: none; the counter holds (saturates) once count equals limit.
module startup_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             match
);

    assign match = (count == limit);

    // Clear wins over enable; stop at the terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !match) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/startup_seq_ctrl.sv
// Lock-qualified startup sequencer for gsr/prld/gts/gwe with host soft-reset req/ack.
// Latency: all outputs registered; 16 lock + 100 gsr + 1 gwe cycles to done with defaults.
// Backpressure: soft_rst_req is a held level, accepted only in S_DONE with a one-cycle ack.
// Optional: STARTUP_JTAG_RST_EN adds jtag_reset_glbl, which restarts at S_GSR without an ack.
module startup_seq_ctrl
    import startup_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int ROC_CYCLES         = ROC_CYCLES_DEF,
    parameter int TOC_CYCLES         = TOC_CYCLES_DEF,
    parameter int CNT_W              = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
`ifdef STARTUP_JTAG_RST_EN
    input  logic               jtag_reset_glbl,
`endif
    output logic               soft_rst_ack,
    output logic               gsr,
    output logic               prld,
    output logic               gts,
    output logic               gwe,
    output logic               done,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROC_LIM  = CNT_W'(ROC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOC_LIM  = (TOC_CYCLES == 0) ? '0 : CNT_W'(TOC_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    logic             ack_nxt;
    logic [3:0]       nxt_out;
    logic             jtag_req;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_limit;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_match;

`ifdef STARTUP_JTAG_RST_EN
    assign jtag_req = jtag_reset_glbl;
`else
    assign jtag_req = 1'b0;
`endif

    // One shared counter; its terminal value depends on which phase is being timed.
    always_comb begin
        cnt_limit = '0;
        case (state)
            S_WAIT_LOCK: cnt_limit = LOCK_LIM;
            S_GSR:       cnt_limit = ROC_LIM;
            S_GTS:       cnt_limit = TOC_LIM;
            default:     cnt_limit = '0;
        endcase
    end

    // Next-state decision; priority from lowest to highest: phase timing, soft request, jtag, lock loss.
    always_comb begin
        nxt     = state;
        ack_nxt = 1'b0;
        case (state)
            S_WAIT_LOCK: if (pll_locked && cnt_match) nxt = S_GSR;
            S_GSR:       if (cnt_match) nxt = (TOC_CYCLES == 0) ? S_GWE : S_GTS;
            S_GTS:       if (cnt_match) nxt = S_GWE;
            S_GWE:       nxt = S_DONE;
            S_DONE: begin
                if (soft_rst_req) begin
                    nxt     = S_GSR;
                    ack_nxt = 1'b1;
                end
            end
            default:     nxt = S_WAIT_LOCK;
        endcase
        if (jtag_req) begin
            nxt     = S_GSR;
            ack_nxt = 1'b0;
        end
        if (!pll_locked) begin
            nxt     = S_WAIT_LOCK;
            ack_nxt = 1'b0;
        end
        nxt_out = state_outputs(nxt);
    end

    // Restart timing on every state change, on any lock drop, and on a jtag restart within S_GSR.
    always_comb begin
        cnt_clr = (nxt != state) || !pll_locked || jtag_req;
        cnt_en  = !cnt_clr;
    end

    startup_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .count (cnt_val),
        .match (cnt_match)
    );

    // State register with outputs registered from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_WAIT_LOCK;
            gsr          <= 1'b1;
            prld         <= 1'b1;
            gts          <= 1'b1;
            gwe          <= 1'b0;
            done         <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= nxt;
            gsr          <= nxt_out[3];
            prld         <= nxt_out[3];
            gts          <= nxt_out[2];
            gwe          <= nxt_out[1];
            done         <= nxt_out[0];
            soft_rst_ack <= ack_nxt;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Bench for startup_seq_ctrl: table vectors, hand sequences and randomized lock/request traffic
// checked against a timeline model (lock run-length, then elapsed cycles since sequence start).
module tb_startup_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters. Instance B: short lock/gsr and a non-zero gts phase.
    localparam int LK_A = 16, ROC_A = 100, TOC_A = 0;
    localparam int LK_B = 4,  ROC_B = 8,   TOC_B = 5;

    logic rst_a = 1'b1, lk_a = 1'b0, req_a = 1'b0, jt_a = 1'b0;
    logic rst_b = 1'b1, lk_b = 1'b0, req_b = 1'b0, jt_b = 1'b0;
    logic ack_a, gsr_a, prld_a, gts_a, gwe_a, done_a;
    logic ack_b, gsr_b, prld_b, gts_b, gwe_b, done_b;
    logic [2:0] st_a, st_b;

    startup_seq_ctrl dut_a (
        .clk(clk), .rst(rst_a), .pll_locked(lk_a), .soft_rst_req(req_a),
`ifdef STARTUP_JTAG_RST_EN
        .jtag_reset_glbl(jt_a),
`endif
        .soft_rst_ack(ack_a), .gsr(gsr_a), .prld(prld_a), .gts(gts_a),
        .gwe(gwe_a), .done(done_a), .state_dbg(st_a)
    );

    startup_seq_ctrl #(.LOCK_STABLE_CYCLES(LK_B), .ROC_CYCLES(ROC_B), .TOC_CYCLES(TOC_B)) dut_b (
        .clk(clk), .rst(rst_b), .pll_locked(lk_b), .soft_rst_req(req_b),
`ifdef STARTUP_JTAG_RST_EN
        .jtag_reset_glbl(jt_b),
`endif
        .soft_rst_ack(ack_b), .gsr(gsr_b), .prld(prld_b), .gts(gts_b),
        .gwe(gwe_b), .done(done_b), .state_dbg(st_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: either counting consecutive locked cycles, or t cycles into the sequence.
    // Phases by t: [0,roc) gsr, [roc,roc+toc) gts, roc+toc gwe, beyond that done.
    typedef struct {
        bit waitm;
        int run;
        int t;
        bit ack;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input bit rst, input bit locked, input bit req,
                                      input bit jtag, input int lk, input int roc, input int toc);
        mdl_t n;
        n = m;
        n.ack = 1'b0;
        if (rst) begin
            n.waitm = 1'b1; n.run = 0; n.t = 0;
        end else if (!locked) begin
            n.waitm = 1'b1; n.run = 0; n.t = 0;
        end else if (jtag) begin
            n.waitm = 1'b0; n.run = 0; n.t = 0;
        end else if (m.waitm) begin
            n.run = m.run + 1;
            if (n.run == lk) begin
                n.waitm = 1'b0; n.run = 0; n.t = 0;
            end
        end else if (m.t > roc + toc) begin
            if (req) begin
                n.t = 0; n.ack = 1'b1;
            end
        end else begin
            n.t = m.t + 1;
        end
        return n;
    endfunction

    // Expected {state_dbg, gsr, prld, gts, gwe, done, ack}.
    function automatic logic [8:0] mdl_out(input mdl_t m, input int roc, input int toc);
        logic [2:0] s;
        bit g, t, w, d;
        if (m.waitm)               s = 3'd0;
        else if (m.t < roc)        s = 3'd1;
        else if (m.t < roc + toc)  s = 3'd2;
        else if (m.t == roc + toc) s = 3'd3;
        else                       s = 3'd4;
        g = m.waitm || (m.t < roc);
        t = m.waitm || (m.t < roc + toc);
        w = !m.waitm && (m.t >= roc + toc);
        d = !m.waitm && (m.t > roc + toc);
        return {s, g, g, t, w, d, m.ack};
    endfunction

    mdl_t ma = '{waitm: 1'b1, run: 0, t: 0, ack: 1'b0};
    mdl_t mb = '{waitm: 1'b1, run: 0, t: 0, ack: 1'b0};

    wire [8:0] out_a = {st_a, gsr_a, prld_a, gts_a, gwe_a, done_a, ack_a};
    wire [8:0] out_b = {st_b, gsr_b, prld_b, gts_b, gwe_b, done_b, ack_b};

    // One clock: advance both models with the inputs seen at the edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        ma = mdl_step(ma, rst_a, lk_a, req_a, jt_a, LK_A, ROC_A, TOC_A);
        mb = mdl_step(mb, rst_b, lk_b, req_b, jt_b, LK_B, ROC_B, TOC_B);
        #1;
        chk("model_a", 32'(out_a), 32'(mdl_out(ma, ROC_A, TOC_A)));
        chk("model_b", 32'(out_b), 32'(mdl_out(mb, ROC_B, TOC_B)));
        chk("gts_gwe_excl_a", 32'(gts_a & gwe_a), 32'd0);
        chk("gts_gwe_excl_b", 32'(gts_b & gwe_b), 32'd0);
    endtask

    typedef struct {
        bit         rst;
        bit         locked;
        bit         req;
        int         cycles;
        logic [2:0] st;
        bit         gsr;
        bit         gts;
        bit         gwe;
        bit         done;
        bit         ack;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        int k;
        int len;
        // rst, locked, req, cycles -> state, gsr, gts, gwe, done, ack after the last cycle
        vecs[0]  = '{1, 0, 0, 2,  3'd0, 1, 1, 0, 0, 0};  // reset values
        vecs[1]  = '{0, 1, 0, 15, 3'd0, 1, 1, 0, 0, 0};  // edge 15: still waiting
        vecs[2]  = '{0, 1, 0, 1,  3'd1, 1, 1, 0, 0, 0};  // edge 16: enter S_GSR
        vecs[3]  = '{0, 1, 1, 5,  3'd1, 1, 1, 0, 0, 0};  // request ignored outside S_DONE
        vecs[4]  = '{0, 1, 0, 94, 3'd1, 1, 1, 0, 0, 0};  // edge 115: gsr still high
        vecs[5]  = '{0, 1, 0, 1,  3'd3, 0, 0, 1, 0, 0};  // edge 116: gsr falls, gts low with gwe
        vecs[6]  = '{0, 1, 0, 1,  3'd4, 0, 0, 1, 1, 0};  // edge 117: done
        vecs[7]  = '{0, 1, 0, 3,  3'd4, 0, 0, 1, 1, 0};  // holds in S_DONE
        vecs[8]  = '{0, 1, 1, 1,  3'd1, 1, 1, 0, 0, 1};  // soft reset accepted, ack pulse
        vecs[9]  = '{0, 1, 0, 99, 3'd1, 1, 1, 0, 0, 0};  // gsr held 100 cycles total
        vecs[10] = '{0, 1, 0, 1,  3'd3, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 1, 0, 1,  3'd4, 0, 0, 1, 1, 0};  // done 101 cycles after ack
        vecs[12] = '{0, 0, 1, 1,  3'd0, 1, 1, 0, 0, 0};  // lock loss beats request, no ack
        vecs[13] = '{0, 1, 0, 10, 3'd0, 1, 1, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 1,  3'd0, 1, 1, 0, 0, 0};  // one-cycle lock drop
        vecs[15] = '{0, 1, 0, 15, 3'd0, 1, 1, 0, 0, 0};  // lock count restarted
        vecs[16] = '{0, 1, 0, 1,  3'd1, 1, 1, 0, 0, 0};  // S_GSR 11 edges later than undisturbed
        vecs[17] = '{0, 1, 0, 50, 3'd1, 1, 1, 0, 0, 0};
        vecs[18] = '{1, 1, 0, 1,  3'd0, 1, 1, 0, 0, 0};  // rst mid S_GSR
        vecs[19] = '{0, 1, 0, 16, 3'd1, 1, 1, 0, 0, 0};

        for (int i = 0; i < NV; i++) begin
            rst_a = vecs[i].rst;
            lk_a  = vecs[i].locked;
            req_a = vecs[i].req;
            for (int c = 0; c < vecs[i].cycles; c++) step();
            chk($sformatf("vec%0d", i), 32'(out_a),
                32'({vecs[i].st, vecs[i].gsr, vecs[i].gsr, vecs[i].gts,
                     vecs[i].gwe, vecs[i].done, vecs[i].ack}));
        end
        req_a = 1'b0;

`ifdef STARTUP_JTAG_RST_EN
        // Finish the sequence, then restart it from S_DONE through the jtag input.
        for (int c = 0; c < ROC_A + 1; c++) step();
        chk("jtag_pre_done", 32'({st_a, done_a}), 32'({3'd4, 1'b1}));
        jt_a = 1'b1;
        step();
        jt_a = 1'b0;
        chk("jtag_restart", 32'(out_a), 32'({3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        // Lock loss still beats a jtag restart.
        jt_a = 1'b1; lk_a = 1'b0;
        step();
        jt_a = 1'b0; lk_a = 1'b1;
        chk("jtag_vs_lock", 32'(st_a), 32'd0);
`endif

        // Instance B: measure how long S_GTS lasts with gsr low and gts high.
        rst_b = 1'b1;
        step(); step();
        rst_b = 1'b0; lk_b = 1'b1;
        k = 0;
        while (st_b != 3'd2 && k < 100) begin
            step();
            k++;
        end
        chk("b_reach_gts_bound", 32'(k < 100), 32'd1);
        len = 0;
        while (st_b == 3'd2 && gsr_b == 1'b0 && gts_b == 1'b1 && len < 50) begin
            len++;
            step();
        end
        chk("b_gts_len", 32'(len), 32'(TOC_B));
        chk("b_after_gts", 32'(st_b), 32'd3);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_a = ($urandom_range(0, 399) == 0);
            rst_b = ($urandom_range(0, 399) == 0);
            lk_a  = ($urandom_range(0, 199) != 0);
            lk_b  = ($urandom_range(0, 29) != 0);
            req_a = ($urandom_range(0, 3) == 0);
            req_b = ($urandom_range(0, 3) == 0);
`ifdef STARTUP_JTAG_RST_EN
            jt_a  = ($urandom_range(0, 299) == 0);
            jt_b  = ($urandom_range(0, 99) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
